// File: rtl/conv_pool_phase_sequencer_if.sv
// Bundle of the phase sequencer's control and status signals.
// The sequencer takes the slave side; whatever drives it (layer logic or a bench) takes the master side.
interface conv_pool_phase_sequencer_if #(
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int MAX_PENDING     = 3
);
  localparam int PCW = $clog2(MAX_PENDING + 1);

  logic                     i_sys_reset;
  logic                     i_sys_enable;
  logic                     i_timestep;
  logic [FIFO_ADDR_WIDTH:0] i_fifo_count;
  logic                     i_conv_busy;
  logic                     i_pool_done;
  logic                     o_conv_enable;
  logic                     o_pool_start;
  logic                     o_pool_pause;
  logic                     o_timestep_ack;
  logic [PCW-1:0]           o_pending_count;
  logic                     o_overflow;
  logic [1:0]               o_phase;
  logic                     o_system_active;

  modport master (
    output i_sys_reset, i_sys_enable, i_timestep, i_fifo_count, i_conv_busy, i_pool_done,
    input  o_conv_enable, o_pool_start, o_pool_pause, o_timestep_ack,
    input  o_pending_count, o_overflow, o_phase, o_system_active
  );

  modport slave (
    input  i_sys_reset, i_sys_enable, i_timestep, i_fifo_count, i_conv_busy, i_pool_done,
    output o_conv_enable, o_pool_start, o_pool_pause, o_timestep_ack,
    output o_pending_count, o_overflow, o_phase, o_system_active
  );
endinterface

// File: rtl/conv_pool_phase_sequencer.sv
// Timestep phase sequencer: queues timestep pulses, drains the conv engine,
// then runs one pooling pass per queued timestep. Pooling stalls with
// hysteresis while the input spike FIFO is backing up.
module conv_pool_phase_sequencer #(
  parameter int FIFO_ADDR_WIDTH  = 4,
  parameter int PAUSE_THRESHOLD  = 12,
  parameter int RESUME_THRESHOLD = 4,
  parameter int MAX_PENDING      = 3,
  parameter bit POOL_ENABLE      = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  conv_pool_phase_sequencer_if.slave    bus
);
  localparam int FW  = FIFO_ADDR_WIDTH + 1;
  localparam int PCW = $clog2(MAX_PENDING + 1);
  localparam logic [FW-1:0]  C_PAUSE  = FW'(PAUSE_THRESHOLD);
  localparam logic [FW-1:0]  C_RESUME = FW'(RESUME_THRESHOLD);
  localparam logic [PCW-1:0] C_MAX    = PCW'(MAX_PENDING);
  localparam logic [PCW-1:0] C_ONE    = PCW'(1);
  localparam logic [PCW-1:0] C_ZERO   = PCW'(0);

  typedef enum logic [1:0] {
    CONV_MODE      = 2'd0,
    CONV_FINISHING = 2'd1,
    POOL_MODE      = 2'd2,
    PAUSE_POOLING  = 2'd3
  } state_t;

  state_t         r_state, w_next_state;
  logic [PCW-1:0] r_pending, w_next_pending;
  logic           r_overflow, w_next_overflow;
  logic           r_pool_start, r_timestep_ack;
  logic           w_retire, w_launch, w_pending_nz;
  logic           w_conv_enable, w_pool_pause;

  assign w_pending_nz = (r_pending != C_ZERO);

  // Next-state decode; a retire always lands in CONV_MODE so at least one conv cycle follows.
  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    w_launch     = 1'b0;
    case (r_state)
      CONV_MODE: begin
        if (bus.i_sys_enable && w_pending_nz) begin
          w_next_state = CONV_FINISHING;
        end else begin
          w_next_state = CONV_MODE;
        end
      end
      CONV_FINISHING: begin
        if (bus.i_sys_enable && !bus.i_conv_busy) begin
          if (POOL_ENABLE) begin
            w_next_state = POOL_MODE;
            w_launch     = 1'b1;
          end else begin
            w_next_state = CONV_MODE;
            w_retire     = 1'b1;
          end
        end else begin
          w_next_state = CONV_FINISHING;
        end
      end
      POOL_MODE: begin
        // pool_done is honoured even while the sequencer is disabled
        if (bus.i_pool_done) begin
          w_next_state = CONV_MODE;
          w_retire     = 1'b1;
        end else if (bus.i_sys_enable && (bus.i_fifo_count >= C_PAUSE)) begin
          w_next_state = PAUSE_POOLING;
        end else begin
          w_next_state = POOL_MODE;
        end
      end
      PAUSE_POOLING: begin
        if (bus.i_pool_done) begin
          w_next_state = CONV_MODE;
          w_retire     = 1'b1;
        end else if (bus.i_sys_enable && (bus.i_fifo_count <= C_RESUME) && !bus.i_conv_busy) begin
          w_next_state = POOL_MODE;
        end else begin
          w_next_state = PAUSE_POOLING;
        end
      end
      default: begin
        w_next_state = CONV_MODE;
      end
    endcase
  end

  // Timestep queue: a simultaneous arrival and retire cancel, even at a full queue.
  always_comb begin
    w_next_pending  = r_pending;
    w_next_overflow = r_overflow;
    if (w_retire && bus.i_timestep) begin
      w_next_pending = r_pending;
    end else if (w_retire) begin
      if (w_pending_nz) begin
        w_next_pending = r_pending - C_ONE;
      end else begin
        w_next_pending = r_pending;
      end
    end else if (bus.i_timestep) begin
      if (r_pending == C_MAX) begin
        w_next_overflow = 1'b1;
      end else begin
        w_next_pending = r_pending + C_ONE;
      end
    end else begin
      w_next_pending = r_pending;
    end
  end

  // State, queue and pulse registers with async reset and synchronous soft clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= CONV_MODE;
      r_pending      <= C_ZERO;
      r_overflow     <= 1'b0;
      r_pool_start   <= 1'b0;
      r_timestep_ack <= 1'b0;
    end else if (bus.i_sys_reset) begin
      r_state        <= CONV_MODE;
      r_pending      <= C_ZERO;
      r_overflow     <= 1'b0;
      r_pool_start   <= 1'b0;
      r_timestep_ack <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_pending      <= w_next_pending;
      r_overflow     <= w_next_overflow;
      r_pool_start   <= w_launch;
      r_timestep_ack <= w_retire;
    end
  end

  // Engine gating decoded from state and sys_enable only (no path from timestep/pool_done/fifo_count).
  always_comb begin
    w_conv_enable = 1'b0;
    w_pool_pause  = 1'b0;
    case (r_state)
      CONV_MODE: begin
        w_conv_enable = bus.i_sys_enable;
        w_pool_pause  = 1'b0;
      end
      CONV_FINISHING: begin
        w_conv_enable = 1'b0;
        w_pool_pause  = 1'b0;
      end
      POOL_MODE: begin
        w_conv_enable = 1'b0;
        w_pool_pause  = !bus.i_sys_enable;
      end
      PAUSE_POOLING: begin
        w_conv_enable = bus.i_sys_enable;
        w_pool_pause  = 1'b1;
      end
      default: begin
        w_conv_enable = 1'b0;
        w_pool_pause  = 1'b0;
      end
    endcase
  end

  assign bus.o_conv_enable   = w_conv_enable;
  assign bus.o_pool_pause    = w_pool_pause;
  assign bus.o_pool_start    = r_pool_start;
  assign bus.o_timestep_ack  = r_timestep_ack;
  assign bus.o_pending_count = r_pending;
  assign bus.o_overflow      = r_overflow;
  assign bus.o_phase         = r_state;
  assign bus.o_system_active = (r_state != CONV_MODE) || w_pending_nz || bus.i_conv_busy;
endmodule
